// File: rtl/decode_pkg.sv
// Shared decode definitions for the instruction decode queue.
//   - instr_id_e : 6-bit enumerated instruction ID (ID_NONE = 0, ID_RI = reserved)
//   - OP_* / FN_* opcode and funct constants
//   - CLS_* bit positions inside the 7-bit class vector
//     {load, store, alu, branch, jump, muldiv, cp0}
//   - EXC_* exception codes
//   - entry_t : per-slot decoded storage record
//   - id_class() : maps an ID onto its one-hot class vector
package decode_pkg;

    typedef enum logic [5:0] {
        ID_NONE = 6'd0, ID_RI,
        ID_LB, ID_LBU, ID_LH, ID_LHU, ID_LW,
        ID_SB, ID_SH, ID_SW,
        ID_ADD, ID_ADDU, ID_SUB, ID_SUBU, ID_SLT, ID_SLTU,
        ID_SLL, ID_SRL, ID_SRA, ID_SLLV, ID_SRLV, ID_SRAV,
        ID_AND, ID_OR, ID_XOR, ID_NOR,
        ID_ADDI, ID_ADDIU, ID_SLTI, ID_SLTIU, ID_ANDI, ID_ORI, ID_XORI, ID_LUI,
        ID_MFHI, ID_MFLO,
        ID_BEQ, ID_BNE, ID_BLEZ, ID_BGTZ, ID_BLTZ, ID_BGEZ,
        ID_J, ID_JAL, ID_JR, ID_JALR,
        ID_MULT, ID_MULTU, ID_DIV, ID_DIVU, ID_MTHI, ID_MTLO,
        ID_MFC0, ID_MTC0, ID_ERET
    } instr_id_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                           OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                           OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI     = 6'h0f, OP_COP0   = 6'h10, OP_LB    = 6'h20,
                           OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                           OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                           OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV  = 6'h07,
                           FN_JR   = 6'h08, FN_JALR = 6'h09, FN_MFHI  = 6'h10,
                           FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
                           FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1a,
                           FN_DIVU = 6'h1b, FN_ADD  = 6'h20, FN_ADDU  = 6'h21,
                           FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24,
                           FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
                           FN_SLT  = 6'h2a, FN_SLTU = 6'h2b, FN_ERET  = 6'h18;

    localparam int CLS_LOAD = 6, CLS_STORE = 5, CLS_ALU = 4, CLS_BRANCH = 3,
                   CLS_JUMP = 2, CLS_MULDIV = 1, CLS_CP0 = 0;

    localparam logic [4:0] EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_RI = 5'd10;

    // instr[25:0] keeps every register/immediate field the head needs
    typedef struct packed {
        logic [25:0] fields;
        logic [5:0]  id;
        logic [6:0]  cls;
        logic [4:0]  exc;
    } entry_t;

    function automatic logic [6:0] id_class(input instr_id_e id);
        logic [6:0] c;
        c = '0;
        case (id)
            ID_LB, ID_LBU, ID_LH, ID_LHU, ID_LW:          c[CLS_LOAD]   = 1'b1;
            ID_SB, ID_SH, ID_SW:                          c[CLS_STORE]  = 1'b1;
            ID_ADD, ID_ADDU, ID_SUB, ID_SUBU, ID_SLT, ID_SLTU,
            ID_SLL, ID_SRL, ID_SRA, ID_SLLV, ID_SRLV, ID_SRAV,
            ID_AND, ID_OR, ID_XOR, ID_NOR,
            ID_ADDI, ID_ADDIU, ID_SLTI, ID_SLTIU, ID_ANDI, ID_ORI,
            ID_XORI, ID_LUI, ID_MFHI, ID_MFLO:            c[CLS_ALU]    = 1'b1;
            ID_BEQ, ID_BNE, ID_BLEZ, ID_BGTZ,
            ID_BLTZ, ID_BGEZ:                             c[CLS_BRANCH] = 1'b1;
            ID_J, ID_JAL, ID_JR, ID_JALR:                 c[CLS_JUMP]   = 1'b1;
            ID_MULT, ID_MULTU, ID_DIV, ID_DIVU,
            ID_MTHI, ID_MTLO:                             c[CLS_MULDIV] = 1'b1;
            ID_MFC0, ID_MTC0, ID_ERET:                    c[CLS_CP0]    = 1'b1;
            default:                                      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational instruction classifier.
// Ports: op/rs/rt/funct - instruction fields; pc_lo - fetch PC bits [1:0]
//        id - instruction enum; cls - one-hot class; exc - exception code
module instr_classify
    import decode_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [5:0] funct,
    input  logic [1:0] pc_lo,
    output logic [5:0] id,
    output logic [6:0] cls,
    output logic [4:0] exc
);

    instr_id_e id_e;

    always_comb begin
        id_e = ID_RI;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD:   id_e = ID_ADD;
                    FN_ADDU:  id_e = ID_ADDU;
                    FN_SUB:   id_e = ID_SUB;
                    FN_SUBU:  id_e = ID_SUBU;
                    FN_SLT:   id_e = ID_SLT;
                    FN_SLTU:  id_e = ID_SLTU;
                    FN_SLL:   id_e = ID_SLL;
                    FN_SRL:   id_e = ID_SRL;
                    FN_SRA:   id_e = ID_SRA;
                    FN_SLLV:  id_e = ID_SLLV;
                    FN_SRLV:  id_e = ID_SRLV;
                    FN_SRAV:  id_e = ID_SRAV;
                    FN_AND:   id_e = ID_AND;
                    FN_OR:    id_e = ID_OR;
                    FN_XOR:   id_e = ID_XOR;
                    FN_NOR:   id_e = ID_NOR;
                    FN_MFHI:  id_e = ID_MFHI;
                    FN_MFLO:  id_e = ID_MFLO;
                    FN_MTHI:  id_e = ID_MTHI;
                    FN_MTLO:  id_e = ID_MTLO;
                    FN_JR:    id_e = ID_JR;
                    FN_JALR:  id_e = ID_JALR;
                    FN_MULT:  id_e = ID_MULT;
                    FN_MULTU: id_e = ID_MULTU;
                    FN_DIV:   id_e = ID_DIV;
                    FN_DIVU:  id_e = ID_DIVU;
                    default:  id_e = ID_RI;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0)      id_e = ID_BLTZ;
                else if (rt == 5'd1) id_e = ID_BGEZ;
            end
            OP_J:     id_e = ID_J;
            OP_JAL:   id_e = ID_JAL;
            OP_BEQ:   id_e = ID_BEQ;
            OP_BNE:   id_e = ID_BNE;
            OP_BLEZ:  id_e = ID_BLEZ;
            OP_BGTZ:  id_e = ID_BGTZ;
            OP_ADDI:  id_e = ID_ADDI;
            OP_ADDIU: id_e = ID_ADDIU;
            OP_SLTI:  id_e = ID_SLTI;
            OP_SLTIU: id_e = ID_SLTIU;
            OP_ANDI:  id_e = ID_ANDI;
            OP_ORI:   id_e = ID_ORI;
            OP_XORI:  id_e = ID_XORI;
            OP_LUI:   id_e = ID_LUI;
            OP_COP0: begin
                // rs[4] is instr[25], the CO bit that marks eret
                if (rs[4] && funct == FN_ERET) id_e = ID_ERET;
                else if (rs == 5'd0)           id_e = ID_MFC0;
                else if (rs == 5'd4)           id_e = ID_MTC0;
            end
            OP_LB:    id_e = ID_LB;
            OP_LBU:   id_e = ID_LBU;
            OP_LH:    id_e = ID_LH;
            OP_LHU:   id_e = ID_LHU;
            OP_LW:    id_e = ID_LW;
            OP_SB:    id_e = ID_SB;
            OP_SH:    id_e = ID_SH;
            OP_SW:    id_e = ID_SW;
            default:  id_e = ID_RI;
        endcase
    end

    assign id  = id_e;
    assign cls = id_class(id_e);
    // fetch misalignment outranks the reserved-instruction exception
    assign exc = (pc_lo != 2'b00) ? EXC_ADEL :
                 (id_e == ID_RI)  ? EXC_RI   : EXC_NONE;

endmodule

// File: rtl/instr_decode_queue.sv
// Registered instruction decode queue between fetch and ID/EX.
// Ports: clk, reset (async, active-high), flush (sync discard)
//        in_valid/in_ready/in_pc/in_instr     - fetch side handshake
//        out_valid/out_ready                  - consumer handshake
//        out_pc/out_id/out_cls/out_rs/out_rt/out_rd/out_shamt/out_imm/out_exc
//                                             - decoded head entry
module instr_decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_id,
    output logic [6:0]      out_cls,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [15:0]     out_imm,
    output logic [4:0]      out_exc
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [PC_W-1:0] pc_mem  [DEPTH];
    entry_t          ent_mem [DEPTH];

    logic       push, pop;
    logic [5:0] dec_id;
    logic [6:0] dec_cls;
    logic [4:0] dec_exc;
    entry_t     head;

    instr_classify u_classify (
        .op    (in_instr[31:26]),
        .rs    (in_instr[25:21]),
        .rt    (in_instr[20:16]),
        .funct (in_instr[5:0]),
        .pc_lo (in_pc[1:0]),
        .id    (dec_id),
        .cls   (dec_cls),
        .exc   (dec_exc)
    );

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // storage is deliberately left out of reset; validity comes from count
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]  <= in_pc;
            ent_mem[wr_ptr] <= '{fields: in_instr[25:0], id: dec_id,
                                 cls: dec_cls, exc: dec_exc};
        end
    end

    // head fields are forced to zero when empty so stale slots never leak out
    assign head      = out_valid ? ent_mem[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_id    = out_valid ? head.id : ID_NONE;
    assign out_cls   = head.cls;
    assign out_exc   = head.exc;
    assign out_rs    = head.fields[25:21];
    assign out_rt    = head.fields[20:16];
    assign out_rd    = head.fields[15:11];
    assign out_shamt = head.fields[10:6];
    assign out_imm   = head.fields[15:0];

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Registered instruction decode queue between fetch and the ID/EX stage. It accepts fetched {pc, instruction} pairs over a valid/ready handshake and decodes each on entry. Entries are held in a DEPTH-entry circular buffer and presented at the head as a compact instruction ID plus class flags, register fields and an exception code. It replaces per-instruction decode wires with an enumerated ID, adds reserved-instruction and fetch-alignment detection, and supports flush and back-pressure.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- PC_W, 32: width of the program-counter field.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears the queue.
- flush  in  1  synchronous discard of all entries (exception or eret redirect).
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  the queue can accept an entry; equals count < DEPTH.
- in_pc  in  PC_W  PC of the offered instruction.
- in_instr  in  32  instruction word.
- out_valid  out  1  the head entry is valid; equals count != 0.
- out_ready  in  1  the consumer takes the head entry.
- out_pc  out  PC_W  PC of the head entry.
- out_id  out  6  instruction enum from the package; ID_NONE when the queue is empty.
- out_cls  out  7  class one-hot {load, store, alu, branch, jump, muldiv, cp0}.
- out_rs, out_rt, out_rd, out_shamt  out  5 each  instruction fields.
- out_imm  out  16  instr[15:0].
- out_exc  out  5  0 = none, 4 = AdEL (fetch misaligned), 10 = RI.

## Operation
- Push: in_valid && in_ready. On a push, decode in_instr and write {pc, instr fields, id, cls, exc} at wr_ptr.
- Pop: out_valid && out_ready. On a pop, advance rd_ptr.
- Simultaneous push and pop:
  - Allowed whenever the queue is not full; count is unchanged.
  - When the queue is full, in_ready=0, so a same-cycle pop does not free a slot for a push.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- flush: clears count, rd_ptr and wr_ptr. flush has priority over a push or pop in the same cycle; that push is dropped.
- Decode, by opcode instr[31:26] and funct instr[5:0]:
  - load: lb, lbu, lh, lhu, lw (0x20, 0x24, 0x21, 0x25, 0x23).
  - store: sb, sh, sw (0x28, 0x29, 0x2b).
  - alu:
    - op 0 with funct add, addu, sub, subu, slt, sltu, sll, srl, sra, sllv, srlv, srav, and, or, xor, nor.
    - immediates addi, addiu, slti, sltiu, andi, ori, xori, lui (0x08–0x0f).
    - mfhi, mflo.
  - branch:
    - beq, bne, blez, bgtz (0x04–0x07).
    - op 0x01 with rt=0 → bltz; op 0x01 with rt=1 → bgez.
  - jump: j (0x02), jal (0x03), jr (funct 0x08), jalr (funct 0x09).
  - muldiv: mult, multu, div, divu (0x18–0x1b), mthi, mtlo.
  - cp0: op 0x10 with rs=0 → mfc0; rs=4 → mtc0; instr[25]=1 and funct 0x18 → eret.
- Any other encoding decodes to ID_RI with out_cls=0 and exc=10.
- Exception priority: if in_pc[1:0] != 0, exc=4 regardless of decode. The id is still stored.
- When out_valid=0, out_id=ID_NONE, out_cls=0 and out_exc=0. The other head fields are don't-care.

## Timing
- Reset values:
  - count=0, pointers=0.
  - in_ready=1, out_valid=0, out_id=ID_NONE, out_cls=0, out_exc=0.
  - out_pc, out_rs, out_rt, out_rd, out_shamt and out_imm are 0.
- Latency: an entry pushed at edge N appears on the out_* ports after edge N (one cycle). There is no combinational in→out bypass.
- in_ready and out_valid are combinational from count only; there is no path from in_valid or out_ready.
- Head outputs are combinational reads of the registered storage at rd_ptr.
- Reset asserted mid-operation empties the queue immediately (asynchronously). Storage contents are not cleared.

## Structure
- Shared package decode_pkg holds:
  - the 6-bit ID enum, including ID_NONE=0, ID_RI and one ID per instruction;
  - opcode and funct constants;
  - class bit positions;
  - exception codes EXC_ADEL=4 and EXC_RI=10.
- One sub-module, instr_classify: purely combinational instr/pc → {id, cls, exc}, instantiated on the write side. The top level holds the buffer, pointers and handshake.

## Test plan
- After reset, push lw (0x8C820004) at pc 0x00003000 → next cycle out_valid=1, out_id=ID_LW, out_cls=load, rs=4, rt=2, imm=0x0004, exc=0.
- DEPTH=4: push 5 entries with out_ready=0 → in_ready=0 after the 4th push. The 5th is accepted only after a pop. Pops return PCs in order: 0x3000, 0x3004, 0x3008, 0x300c, 0x3010 (wrap verified).
- Push the word 0xFC000000 → exc=10, id=ID_RI, cls=0. Push addu at pc 0x00003002 → exc=4.
- With 2 entries held, assert flush together with a push → next cycle out_valid=0, in_ready=1, and the pushed entry is absent.
- Half-full queue, continuous push and pop for 20 cycles → count stays constant and the order is preserved.
- With 3 entries held, assert reset asynchronously mid-cycle → out_valid=0 immediately. After release, a push of eret (0x42000018) yields ID_ERET with cls=cp0.
